// File: rtl/bullet_controller_if.sv
// Signal bundle between the player bullet controller and the game logic around it:
// ship position, fire button and collision result in; bullet box and score out.
interface bullet_controller_if;
  logic               fsync;
  logic               fire;
  logic signed [11:0] ship_cx;
  logic signed [11:0] ship_top;
  logic               alien_hit;
  logic               bullet_active;
  logic signed [11:0] bullet_left;
  logic signed [11:0] bullet_right;
  logic signed [11:0] bullet_top;
  logic signed [11:0] bullet_bottom;
  logic [7:0]         hit_count;

  modport master (
    output fsync, fire, ship_cx, ship_top, alien_hit,
    input  bullet_active, bullet_left, bullet_right, bullet_top, bullet_bottom, hit_count
  );

  modport slave (
    input  fsync, fire, ship_cx, ship_top, alien_hit,
    output bullet_active, bullet_left, bullet_right, bullet_top, bullet_bottom, hit_count
  );
endinterface

// File: rtl/bullet_controller.sv
// Player bullet: launches on a fire press, climbs SPEED rows per frame, retires on an
// alien hit or at the top of the screen, then waits COOLDOWN_FRAMES frames before re-arming.
module bullet_controller #(
  parameter int BULLET_W        = 4,
  parameter int BULLET_H        = 12,
  parameter int SPEED           = 8,
  parameter int SCREEN_TOP      = 0,
  parameter int COOLDOWN_FRAMES = 15
) (
  input logic               pixel_clk,
  input logic               rst,
  bullet_controller_if.slave bus
);

  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic signed [11:0] HALF_W   = 12'(BULLET_W / 2);
  localparam logic signed [11:0] W_M1     = 12'(BULLET_W - 1);
  localparam logic signed [11:0] H_S      = 12'(BULLET_H);
  localparam logic signed [11:0] SPEED_S  = 12'(SPEED);
  localparam logic signed [11:0] EXIT_ROW = 12'(SCREEN_TOP + SPEED);
  localparam logic [CD_W-1:0]    CD_INIT  = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0]    CD_ONE   = CD_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    COOLDOWN
  } state_e;

  state_e             state_q, state_d;
  logic               fire_q;
  logic               pending_q, pending_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               active_q, active_d;
  logic signed [11:0] left_q, left_d;
  logic signed [11:0] right_q, right_d;
  logic signed [11:0] top_q, top_d;
  logic signed [11:0] bottom_q, bottom_d;
  logic [7:0]         hit_q, hit_d;
  logic               fire_rise;
  logic signed [11:0] launch_left;

  assign fire_rise   = bus.fire & ~fire_q;
  assign launch_left = bus.ship_cx - HALF_W;

  // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cd_d      = cd_q;
    active_d  = active_q;
    left_d    = left_q;
    right_d   = right_q;
    top_d     = top_q;
    bottom_d  = bottom_q;
    hit_d     = hit_q;

    // Presses outside IDLE are dropped so a held button cannot auto-fire.
    if (state_q == IDLE && fire_rise) pending_d = 1'b1;

    if (bus.fsync) begin
      case (state_q)
        IDLE: begin
          if (pending_q || fire_rise) begin
            left_d    = launch_left;
            right_d   = launch_left + W_M1;
            top_d     = bus.ship_top - H_S;
            bottom_d  = bus.ship_top - 12'sd1;
            active_d  = 1'b1;
            pending_d = 1'b0;
            state_d   = FLYING;
          end
        end
        FLYING: begin
          // The hit refers to the box shown during the frame that just ended, so it beats the move.
          if (bus.alien_hit) begin
            active_d = 1'b0;
            if (hit_q != 8'hFF) hit_d = hit_q + 8'd1;
            cd_d     = CD_INIT;
            state_d  = COOLDOWN;
          end else if (top_q < EXIT_ROW) begin
            active_d = 1'b0;
            cd_d     = CD_INIT;
            state_d  = COOLDOWN;
          end else begin
            top_d    = top_q - SPEED_S;
            bottom_d = bottom_q - SPEED_S;
          end
        end
        COOLDOWN: begin
          if (cd_q <= CD_ONE) state_d = IDLE;
          else                cd_d    = cd_q - CD_ONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      fire_q    <= 1'b0;
      pending_q <= 1'b0;
      cd_q      <= '0;
      active_q  <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      top_q     <= '0;
      bottom_q  <= '0;
      hit_q     <= '0;
    end else begin
      state_q   <= state_d;
      fire_q    <= bus.fire;
      pending_q <= pending_d;
      cd_q      <= cd_d;
      active_q  <= active_d;
      left_q    <= left_d;
      right_q   <= right_d;
      top_q     <= top_d;
      bottom_q  <= bottom_d;
      hit_q     <= hit_d;
    end
  end

  assign bus.bullet_active = active_q;
  assign bus.bullet_left   = left_q;
  assign bus.bullet_right  = right_q;
  assign bus.bullet_top    = top_q;
  assign bus.bullet_bottom = bottom_q;
  assign bus.hit_count     = hit_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller: launch geometry, flight, top exit, hit scoring,
// cooldown lockout, hit-counter saturation and asynchronous mid-flight reset.
module tb_bullet_controller;

  logic pixel_clk = 1'b0;
  logic rst;

  bullet_controller_if bus ();

  bullet_controller #(
    .BULLET_W       (4),
    .BULLET_H       (12),
    .SPEED          (8),
    .SCREEN_TOP     (0),
    .COOLDOWN_FRAMES(15)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // One fsync pulse; inputs change on the falling edge, outputs are read on the next falling edge.
  task automatic frame(input logic hit = 1'b0);
    @(negedge pixel_clk);
    bus.fsync     = 1'b1;
    bus.alien_hit = hit;
    @(negedge pixel_clk);
    bus.fsync     = 1'b0;
    bus.alien_hit = 1'b0;
  endtask

  task automatic pulse_fire();
    @(negedge pixel_clk);
    bus.fire = 1'b1;
    @(negedge pixel_clk);
    bus.fire = 1'b0;
  endtask

  task automatic cooldown();
    repeat (15) frame(1'b0);
  endtask

  task automatic check_box(input string tag, input int l, input int r, input int t, input int b);
    check({tag, ".left"},   bus.bullet_left,   l);
    check({tag, ".right"},  bus.bullet_right,  r);
    check({tag, ".top"},    bus.bullet_top,    t);
    check({tag, ".bottom"}, bus.bullet_bottom, b);
  endtask

  int exp_hits;

  initial begin
    rst           = 1'b0;
    bus.fsync     = 1'b0;
    bus.fire      = 1'b0;
    bus.ship_cx   = 12'sd0;
    bus.ship_top  = 12'sd0;
    bus.alien_hit = 1'b0;
    exp_hits      = 0;

    // 1. Reset and idle frames without a press
    repeat (3) @(negedge pixel_clk);
    check("rst.active", bus.bullet_active, 0);
    check("rst.hits",   bus.hit_count,     0);
    rst = 1'b1;
    repeat (3) frame(1'b0);
    check("idle.active", bus.bullet_active, 0);
    check_box("idle", 0, 0, 0, 0);
    check("idle.hits", bus.hit_count, 0);

    // 2. Launch and flight
    bus.ship_cx  = 12'sd320;
    bus.ship_top = 12'sd440;
    pulse_fire();
    frame(1'b0);
    check("launch.active", bus.bullet_active, 1);
    check_box("launch", 318, 321, 428, 439);
    frame(1'b0);
    check_box("fly1", 318, 321, 420, 431);
    frame(1'b0);
    check_box("fly2", 318, 321, 412, 423);

    // 4. Hit, then cooldown lockout with held and toggled fire
    frame(1'b1);
    exp_hits++;
    check("hit.active", bus.bullet_active, 0);
    check("hit.hits",   bus.hit_count,     exp_hits);
    check("hit.top_hold", bus.bullet_top, 412);
    for (int i = 0; i < 15; i++) begin
      bus.fire = (i < 7) ? 1'b1 : 1'(i % 2);
      frame(1'b0);
      check($sformatf("cd%0d.active", i), bus.bullet_active, 0);
    end
    bus.fire = 1'b0;
    repeat (2) @(negedge pixel_clk);
    check("cd_end.active", bus.bullet_active, 0);
    pulse_fire();
    frame(1'b0);
    check("rearm.active", bus.bullet_active, 1);
    check("rearm.top",    bus.bullet_top,    428);

    // alien_hit outside fsync must be ignored
    @(negedge pixel_clk);
    bus.alien_hit = 1'b1;
    repeat (4) @(negedge pixel_clk);
    bus.alien_hit = 1'b0;
    check("stray_hit.active", bus.bullet_active, 1);
    check("stray_hit.hits",   bus.hit_count,     exp_hits);
    check("stray_hit.top",    bus.bullet_top,    428);
    frame(1'b0);
    check("stray_hit.move", bus.bullet_top, 420);
    frame(1'b1);
    exp_hits++;
    check("hit2.hits", bus.hit_count, exp_hits);
    cooldown();

    // 3. Top exit from a low ship
    bus.ship_top = 12'sd30;
    pulse_fire();
    frame(1'b0);
    check_box("low", 318, 321, 18, 29);
    frame(1'b0);
    check("exit1.top", bus.bullet_top, 10);
    frame(1'b0);
    check("exit2.top",    bus.bullet_top,    2);
    check("exit2.bottom", bus.bullet_bottom, 13);
    check("exit2.active", bus.bullet_active, 1);
    frame(1'b0);
    check("exit3.active", bus.bullet_active, 0);
    check("exit3.hits",   bus.hit_count,     exp_hits);
    cooldown();

    // Launch above the screen top yields a negative top, retired on the next frame
    bus.ship_top = 12'sd5;
    pulse_fire();
    frame(1'b0);
    check("neg.top",    bus.bullet_top,    -7);
    check("neg.bottom", bus.bullet_bottom, 4);
    frame(1'b0);
    check("neg.active", bus.bullet_active, 0);
    cooldown();

    // 5. Saturation of the hit counter
    bus.ship_top = 12'sd440;
    for (int i = 0; i < 256; i++) begin
      pulse_fire();
      frame(1'b0);
      frame(1'b1);
      if (exp_hits < 255) exp_hits++;
      cooldown();
      if (i == 252) check("sat.reach", bus.hit_count, 255);
    end
    check("sat.hold", bus.hit_count, 255);

    // 6. Asynchronous reset mid-flight
    pulse_fire();
    frame(1'b0);
    repeat (16) frame(1'b0);
    check("mid.top",    bus.bullet_top,    300);
    check("mid.active", bus.bullet_active, 1);
    @(negedge pixel_clk);
    #2 rst = 1'b0;
    #1;
    check("async.active", bus.bullet_active, 0);
    check_box("async", 0, 0, 0, 0);
    check("async.hits", bus.hit_count, 0);
    repeat (3) @(negedge pixel_clk);
    rst = 1'b1;
    repeat (3) frame(1'b0);
    check("post_rst.active", bus.bullet_active, 0);
    pulse_fire();
    frame(1'b0);
    check("post_rst.launch", bus.bullet_active, 1);
    check("post_rst.top",    bus.bullet_top,    428);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bullet_controller.md
Name: bullet_controller

Overview:
- Generates the player bullet consumed by the bullet/alien collision logic.
- Drives `bullet_active` and the bullet bounding box (left/right/top/bottom), and consumes `alien_hit` to retire the bullet.
- Launches on a fire-button press, moves the bullet up the screen once per frame (`fsync`), and retires it on a hit or on leaving the top of the screen.
- Enforces a frame-counted cooldown between shots and keeps a saturating hit counter for the score logic.

Parameters:
- BULLET_W, 4, bullet width in pixels (even, >=2)
- BULLET_H, 12, bullet height in pixels (>=1)
- SPEED, 8, upward pixels moved per frame (>=1)
- SCREEN_TOP, 0, topmost visible row
- COOLDOWN_FRAMES, 15, frames between bullet retirement and re-arm (>=1)

Ports:
- pixel_clk  input  1  sole clock
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- fsync  input  1  one-cycle frame-start pulse
- fire  input  1  fire button level, already synchronised to pixel_clk
- ship_cx  input  signed 12  ship horizontal centre
- ship_top  input  signed 12  ship top row
- alien_hit  input  1  collision result, valid on fsync cycles
- bullet_active  output  1  bullet on screen
- bullet_left  output  signed 12  bullet left column
- bullet_right  output  signed 12  bullet right column
- bullet_top  output  signed 12  bullet top row
- bullet_bottom  output  signed 12  bullet bottom row
- hit_count  output  8  hits scored, saturating

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state=IDLE; `bullet_active`=0; all four position outputs=0; `hit_count`=0.
  - `fire_q`=0; `fire_pending`=0; `cd_cnt`=0.
- All outputs are registered. The FSM advances only on `fsync` cycles, except `fire` edge capture, which happens every cycle.
- Fire edge detection:
  - `fire_q` registers `fire` every cycle; rise = `fire & ~fire_q`.
  - A rise sets `fire_pending` only while state=IDLE. Rises in FLYING or COOLDOWN are discarded, so a held button does not auto-fire.
- IDLE:
  - On `fsync` with (`fire_pending` or rise in the same cycle):
    - `bullet_left` = `ship_cx` - BULLET_W/2
    - `bullet_right` = `bullet_left` + BULLET_W - 1
    - `bullet_top` = `ship_top` - BULLET_H
    - `bullet_bottom` = `ship_top` - 1
    - `bullet_active`=1; clear `fire_pending`; go to FLYING.
  - Otherwise hold.
- FLYING, on `fsync`, in priority order:
  1. `alien_hit`=1: `bullet_active`=0; `hit_count`+=1 (holds at 255); `cd_cnt`=COOLDOWN_FRAMES; go to COOLDOWN.
  2. `bullet_top` < SCREEN_TOP + SPEED: `bullet_active`=0; `cd_cnt`=COOLDOWN_FRAMES; go to COOLDOWN. No score.
  3. Otherwise `bullet_top` and `bullet_bottom` both decrease by SPEED; left/right unchanged.
  - `alien_hit` on non-fsync cycles, or in any state other than FLYING, is ignored.
  - The hit is judged against the positions shown during the frame just ended, i.e. the current registered outputs. A hit on that fsync takes priority over the move.
- COOLDOWN:
  - On `fsync`: if `cd_cnt` <= 1, go to IDLE; else `cd_cnt` -= 1.
  - COOLDOWN therefore lasts exactly COOLDOWN_FRAMES fsyncs.
- Positions hold their last value while `bullet_active`=0. Consumers must gate on `bullet_active`.
- Arithmetic:
  - All position maths is signed 12-bit; wrap is not checked.
  - Launch with `ship_top` < BULLET_H yields a negative top. It is retired by the top-exit rule on the next fsync.
- Mid-operation reset returns to the reset values immediately, regardless of state. No bullet is relaunched after reset release until a new `fire` rise occurs.

Test Plan:
1. Reset, then release with `fire`=0 and 3 fsyncs -> `bullet_active`=0, all positions 0, `hit_count`=0, still IDLE.
2. Launch and flight:
   - Stimulus: `ship_cx`=320, `ship_top`=440; pulse `fire` 1 cycle; next fsync.
   - Required: `bullet_active`=1, left=318, right=321, top=428, bottom=439.
   - Next 2 fsyncs: top=420 then 412, bottom=431 then 423.
3. Top exit:
   - Stimulus: launch with `ship_top`=30 (top=18); step fsyncs.
   - Required: top 18 -> 10; next fsync (10 < 8 false) -> top 2; next fsync (2 < 8) -> `bullet_active`=0, `hit_count` unchanged.
4. Hit and cooldown:
   - Stimulus: `alien_hit`=1 on the fsync after launch.
   - Required: `bullet_active`=0, `hit_count`=1.
   - Hold `fire`=1 and pulse it during cooldown -> no launch for 15 fsyncs.
   - Fire rise after the 15th fsync -> launch on the 16th.
   - `alien_hit`=1 without fsync -> no effect.
5. Saturation: 256 launch+hit cycles -> `hit_count` stays 255.
6. Reset mid-flight: assert `rst`=0 while FLYING at top=300 -> `bullet_active`=0 and positions 0 immediately (asynchronously); after release, no launch without a new fire edge.
